// File: rtl/soc_mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory port of soc_mem_arbiter.
// slave is the arbiter's view; master is the core-plus-memory side.
interface soc_mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  i_inst_req;
    logic [ADDR_WIDTH-1:0] i_inst_addr;
    logic                  o_inst_gnt;
    logic                  o_inst_rvalid;
    logic [DATA_WIDTH-1:0] o_inst_rdata;

    logic                  i_data_req;
    logic                  i_data_we;
    logic [BE_WIDTH-1:0]   i_data_be;
    logic [ADDR_WIDTH-1:0] i_data_addr;
    logic [DATA_WIDTH-1:0] i_data_wdata;
    logic                  o_data_gnt;
    logic                  o_data_rvalid;
    logic [DATA_WIDTH-1:0] o_data_rdata;

    logic                  o_mem_en;
    logic [BE_WIDTH-1:0]   o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport slave (
        input  i_inst_req, i_inst_addr,
        output o_inst_gnt, o_inst_rvalid, o_inst_rdata,
        input  i_data_req, i_data_we, i_data_be, i_data_addr, i_data_wdata,
        output o_data_gnt, o_data_rvalid, o_data_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_inst_req, i_inst_addr,
        input  o_inst_gnt, o_inst_rvalid, o_inst_rdata,
        output i_data_req, i_data_we, i_data_be, i_data_addr, i_data_wdata,
        input  o_data_gnt, o_data_rvalid, o_data_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/soc_mem_arbiter.sv
// Shares one single-port synchronous memory between instruction-fetch and data ports,
// one outstanding transaction at a time, with fixed-priority or round-robin arbitration.
module soc_mem_arbiter #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ARB_MODE    = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    soc_mem_arbiter_if.slave   bus
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic {IDLE, BUSY} state_e;
    typedef enum logic {OWN_INST, OWN_DATA} owner_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    owner_e                 owner_q, owner_d;
    owner_e                 rr_last_q, rr_last_d;
    logic                   ack_q, ack_d;

    logic                   bus_free_c;
    logic                   gnt_inst_c;
    logic                   gnt_data_c;
    logic                   rd_done_c;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_INST;
            rr_last_q <= OWN_INST;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            ack_q     <= ack_d;
        end
    end

    // The final BUSY cycle is free so reads can be issued back to back
    assign bus_free_c = (state_q == IDLE) || (cnt_q == '0);
    assign rd_done_c  = !i_rst && (state_q == BUSY) && (cnt_q == '0);

    // Arbitration
    always_comb begin
        gnt_inst_c = 1'b0;
        gnt_data_c = 1'b0;
        if (!i_rst && bus_free_c) begin
            if (bus.i_inst_req && bus.i_data_req) begin
                if ((ARB_MODE == 0) || (rr_last_q == OWN_INST)) begin
                    gnt_data_c = 1'b1;
                end else begin
                    gnt_inst_c = 1'b1;
                end
            end else begin
                gnt_inst_c = bus.i_inst_req;
                gnt_data_c = bus.i_data_req;
            end
        end
    end

    // Next state: stores never leave IDLE, reads hold BUSY for WAIT_STATES cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        ack_d     = 1'b0;
        if (state_q == BUSY) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end
        end
        if (gnt_inst_c || gnt_data_c) begin
            owner_d   = gnt_data_c ? OWN_DATA : OWN_INST;
            rr_last_d = gnt_data_c ? OWN_DATA : OWN_INST;
            if (gnt_data_c && bus.i_data_we) begin
                ack_d = 1'b1;
            end else begin
                state_d = BUSY;
                cnt_d   = CNT_WIDTH'(WAIT_STATES - 1);
            end
        end
    end

    // Outputs
    always_comb begin
        bus.o_inst_gnt    = gnt_inst_c;
        bus.o_data_gnt    = gnt_data_c;
        bus.o_inst_rvalid = 1'b0;
        bus.o_inst_rdata  = '0;
        bus.o_data_rvalid = 1'b0;
        bus.o_data_rdata  = '0;
        bus.o_mem_en      = 1'b0;
        bus.o_mem_we      = '0;
        bus.o_mem_addr    = '0;
        bus.o_mem_wdata   = '0;
        if (gnt_inst_c) begin
            bus.o_mem_en   = 1'b1;
            bus.o_mem_addr = bus.i_inst_addr;
        end
        if (gnt_data_c) begin
            bus.o_mem_en    = 1'b1;
            bus.o_mem_addr  = bus.i_data_addr;
            bus.o_mem_wdata = bus.i_data_wdata;
            bus.o_mem_we    = bus.i_data_we ? bus.i_data_be : BE_WIDTH'(0);
        end
        if (rd_done_c && (owner_q == OWN_INST)) begin
            bus.o_inst_rvalid = 1'b1;
            bus.o_inst_rdata  = bus.i_mem_rdata;
        end
        if (rd_done_c && (owner_q == OWN_DATA)) begin
            bus.o_data_rvalid = 1'b1;
            bus.o_data_rdata  = bus.i_mem_rdata;
        end
        if (ack_q && !i_rst) begin
            bus.o_data_rvalid = 1'b1;
        end
    end
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Bench for soc_mem_arbiter: two instances (WAIT_STATES=1/fixed priority, WAIT_STATES=3/round-robin)
// driven one at a time and checked each cycle against a transaction-level model.
module tb_soc_mem_arbiter;
    logic        clk;
    logic        rst;
    logic        sel;
    logic        rst_a, rst_b;

    logic        inst_req;
    logic [9:0]  inst_addr;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [9:0]  data_addr;
    logic [31:0] data_wdata;
    logic [31:0] mem_rdata;

    soc_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_a ();
    soc_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus_b ();

    soc_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(1), .ARB_MODE(0)) u_dut_a (
        .i_clk(clk), .i_rst(rst_a), .bus(bus_a));
    soc_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(3), .ARB_MODE(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b), .bus(bus_b));

    // The unselected instance sits in reset with its requests masked
    assign rst_a = rst || sel;
    assign rst_b = rst || !sel;

    assign bus_a.i_inst_req   = !sel && inst_req;
    assign bus_a.i_inst_addr  = inst_addr;
    assign bus_a.i_data_req   = !sel && data_req;
    assign bus_a.i_data_we    = data_we;
    assign bus_a.i_data_be    = data_be;
    assign bus_a.i_data_addr  = data_addr;
    assign bus_a.i_data_wdata = data_wdata;
    assign bus_a.i_mem_rdata  = mem_rdata;
    assign bus_b.i_inst_req   = sel && inst_req;
    assign bus_b.i_inst_addr  = inst_addr;
    assign bus_b.i_data_req   = sel && data_req;
    assign bus_b.i_data_we    = data_we;
    assign bus_b.i_data_be    = data_be;
    assign bus_b.i_data_addr  = data_addr;
    assign bus_b.i_data_wdata = data_wdata;
    assign bus_b.i_mem_rdata  = mem_rdata;

    logic        o_gi, o_gd, o_iv, o_dv, o_en;
    logic [31:0] o_ir, o_dr, o_wd;
    logic [3:0]  o_we;
    logic [9:0]  o_ad;
    assign o_gi = sel ? bus_b.o_inst_gnt    : bus_a.o_inst_gnt;
    assign o_gd = sel ? bus_b.o_data_gnt    : bus_a.o_data_gnt;
    assign o_iv = sel ? bus_b.o_inst_rvalid : bus_a.o_inst_rvalid;
    assign o_ir = sel ? bus_b.o_inst_rdata  : bus_a.o_inst_rdata;
    assign o_dv = sel ? bus_b.o_data_rvalid : bus_a.o_data_rvalid;
    assign o_dr = sel ? bus_b.o_data_rdata  : bus_a.o_data_rdata;
    assign o_en = sel ? bus_b.o_mem_en      : bus_a.o_mem_en;
    assign o_we = sel ? bus_b.o_mem_we      : bus_a.o_mem_we;
    assign o_ad = sel ? bus_b.o_mem_addr    : bus_a.o_mem_addr;
    assign o_wd = sel ? bus_b.o_mem_wdata   : bus_a.o_mem_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with a WAIT_STATES-deep read pipe; junk is returned outside valid slots
    logic [31:0] mem  [32];
    logic [31:0] pipe [16];
    always @(posedge clk) begin
        for (int i = 15; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= o_en ? mem[o_ad[4:0]] : $urandom;
        if (o_en) begin
            for (int b = 0; b < 4; b++) begin
                if (o_we[b]) mem[o_ad[4:0]][8*b +: 8] <= o_wd[8*b +: 8];
            end
        end
    end
    assign mem_rdata = sel ? pipe[2] : pipe[0];

    // Reference model state
    int          n_vec, n_err, cyc;
    int          rd_due, ack_due;
    logic        rd_port;
    logic [31:0] rd_data;
    logic        rr_last;
    logic [31:0] ref_mem [32];

    logic        s_gi, s_gd, s_iv, s_dv, s_en;
    logic [31:0] s_ir, s_dr, s_wd;
    logic [3:0]  s_we;
    logic [9:0]  s_ad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d sel=%0d got=%h exp=%h", tag, cyc, sel, got, exp);
        end
    endtask

    // One clock: predict from the model, compare, advance the model, then let requesters see gnt
    task automatic step();
        logic        egi, egd, eiv, edv, een;
        logic [31:0] eir, edr, ewd;
        logic [3:0]  ewe;
        logic [9:0]  ead;
        int          ws;
        logic        mode;
        @(negedge clk);
        ws = sel ? 3 : 1;
        mode = sel;
        egi = 0; egd = 0; eiv = 0; edv = 0; een = 0;
        eir = '0; edr = '0; ewd = '0; ewe = '0; ead = '0;
        if (rst) begin
            rd_due = -1; ack_due = -1; rr_last = 1'b0;
        end else begin
            if (rd_due == cyc && rd_port == 1'b0) begin eiv = 1; eir = rd_data; end
            if (rd_due == cyc && rd_port == 1'b1) begin edv = 1; edr = rd_data; end
            if (ack_due == cyc) edv = 1;
            if (rd_due < 0 || rd_due == cyc) begin
                egd = data_req && (!inst_req || mode == 1'b0 || rr_last == 1'b0);
                egi = inst_req && !egd;
            end
            if (rd_due == cyc) rd_due = -1;
            if (egi) begin
                een = 1; ead = inst_addr; rr_last = 1'b0;
                rd_due = cyc + ws; rd_port = 1'b0; rd_data = ref_mem[inst_addr[4:0]];
            end
            if (egd) begin
                een = 1; ead = data_addr; ewd = data_wdata; rr_last = 1'b1;
                if (data_we) begin
                    ewe = data_be;
                    ack_due = cyc + 1;
                    for (int b = 0; b < 4; b++)
                        if (data_be[b]) ref_mem[data_addr[4:0]][8*b +: 8] = data_wdata[8*b +: 8];
                end else begin
                    rd_due = cyc + ws; rd_port = 1'b1; rd_data = ref_mem[data_addr[4:0]];
                end
            end
        end
        s_gi = o_gi; s_gd = o_gd; s_iv = o_iv; s_dv = o_dv; s_en = o_en;
        s_ir = o_ir; s_dr = o_dr; s_wd = o_wd; s_we = o_we; s_ad = o_ad;
        check("gnt",     64'({s_gi, s_gd}), 64'({egi, egd}));
        check("inst_rv", 64'({s_iv, s_ir}), 64'({eiv, eir}));
        check("data_rv", 64'({s_dv, s_dr}), 64'({edv, edr}));
        check("mem",     64'({s_en, s_we, s_ad, s_wd}), 64'({een, ewe, ead, ewd}));
        @(posedge clk);
        #1;
        cyc++;
        if (s_gi) inst_req = 1'b0;
        if (s_gd) data_req = 1'b0;
    endtask

    task automatic drain();
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (6) step();
    endtask

    task automatic do_store(input logic [9:0] a, input logic [3:0] be, input logic [31:0] wd,
                            output logic [3:0] we_seen);
        logic ok = 1'b0;
        we_seen = '0;
        data_req = 1'b1; data_we = 1'b1; data_addr = a; data_be = be; data_wdata = wd;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (s_gd) begin ok = 1'b1; we_seen = s_we; end
        end
        check("store_gnt", 64'(ok), 64'(1));
    endtask

    task automatic do_load(input logic [9:0] a, output logic [31:0] rd);
        logic ok = 1'b0;
        logic granted = 1'b0;
        rd = '0;
        data_req = 1'b1; data_we = 1'b0; data_addr = a; data_be = 4'h0; data_wdata = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (granted && s_dv) begin ok = 1'b1; rd = s_dr; end
            if (s_gd) granted = 1'b1;
        end
        check("load_done", 64'(ok), 64'(1));
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if (!inst_req && ($urandom % 3) == 0) begin
                inst_req = 1'b1; inst_addr = 10'($urandom_range(0, 31));
            end else if (inst_req && ($urandom % 10) == 0) begin
                inst_req = 1'b0;
            end
            if (!data_req && ($urandom % 3) == 0) begin
                data_req = 1'b1; data_we = 1'($urandom); data_be = 4'($urandom);
                data_addr = 10'($urandom_range(0, 31)); data_wdata = $urandom;
            end else if (data_req && ($urandom % 10) == 0) begin
                data_req = 1'b0;
            end
            step();
        end
        drain();
    endtask

    task automatic preload();
        logic [3:0] we_seen;
        for (int a = 0; a < 32; a++) begin
            logic [31:0] v;
            v = (a == 5) ? 32'h1111_1111 : (a == 16) ? 32'h0000_0013 : $urandom;
            do_store(10'(a), 4'hF, v, we_seen);
        end
        drain();
    endtask

    initial begin
        logic [3:0]  we_seen;
        logic [31:0] rd;
        logic [7:0]  seq8;
        logic [3:0]  seq4;
        logic [10:0] gv, rv;
        int          ngr;
        logic        any_dv;

        n_vec = 0; n_err = 0; cyc = 0;
        rd_due = -1; ack_due = -1; rd_port = 1'b0; rd_data = '0; rr_last = 1'b0;
        for (int a = 0; a < 32; a++) ref_mem[a] = '0;
        sel = 1'b0; rst = 1'b1;
        inst_req = 1'b1; inst_addr = 10'd0;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hF; data_addr = 10'd0; data_wdata = 32'hA5A5_0000;

        // Reset held 3 cycles with both ports requesting, then grant right after release
        repeat (3) step();
        rst = 1'b0;
        step();
        check("t1_first_gnt", 64'({s_gi, s_gd}), 64'(2'b01));
        drain();
        preload();

        // Single fetch, WAIT_STATES=1
        inst_req = 1'b1; inst_addr = 10'h010;
        step();
        check("t2_gnt", 64'({s_gi, s_en, s_ad}), 64'({1'b1, 1'b1, 10'h010}));
        step();
        check("t2_rdata", 64'({s_iv, s_ir}), 64'({1'b1, 32'h0000_0013}));

        // Persistent conflict, fixed priority
        seq8 = '0;
        for (int i = 0; i < 8; i++) begin
            inst_req = 1'b1;
            if (!data_req) begin
                data_req = 1'b1; data_we = 1'b0; data_addr = 10'($urandom_range(0, 31));
            end
            step();
            seq8 = {seq8[6:0], s_gd};
        end
        check("t3_order_m0", 64'(seq8), 64'(8'hFF));
        drain();

        // Partial store then reload
        do_store(10'd5, 4'b0011, 32'hDEAD_BEEF, we_seen);
        check("t4_we", 64'(we_seen), 64'(4'b0011));
        step();
        check("t4_ack", 64'({s_dv, s_dr}), 64'({1'b1, 32'h0}));
        do_load(10'd5, rd);
        check("t4_reload", 64'(rd), 64'(32'h1111_BEEF));
        do_store(10'd6, 4'b0000, 32'hFFFF_FFFF, we_seen);
        do_load(10'd6, rd);
        check("t4_be0", 64'(rd), 64'(ref_mem[6]));
        drain();
        run_random(300);

        // Second instance: WAIT_STATES=3, round-robin
        sel = 1'b1; rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        preload();

        rst = 1'b1; step(); rst = 1'b0;
        seq4 = '0; ngr = 0;
        for (int i = 0; i < 20 && ngr < 4; i++) begin
            if (!inst_req) begin inst_req = 1'b1; inst_addr = 10'($urandom_range(0, 31)); end
            if (!data_req) begin data_req = 1'b1; data_we = 1'b0; data_addr = 10'($urandom_range(0, 31)); end
            step();
            if (s_gi || s_gd) begin seq4 = {seq4[2:0], s_gd}; ngr++; end
        end
        check("t3_order_m1", 64'({ngr[3:0], seq4}), 64'({4'd4, 4'b1010}));
        drain();

        // Back-to-back fetches, WAIT_STATES=3
        gv = '0; rv = '0; ngr = 0;
        for (int i = 0; i < 11; i++) begin
            if (!inst_req && ngr < 3) begin inst_req = 1'b1; inst_addr = 10'($urandom_range(0, 31)); end
            step();
            gv[i] = s_gi; rv[i] = s_iv;
            if (s_gi) ngr++;
        end
        check("t5_gnt_cycles", 64'(gv), 64'(11'h049));
        check("t5_rv_cycles",  64'(rv), 64'(11'h248));
        drain();

        // Reset abandons an outstanding load
        data_req = 1'b1; data_we = 1'b0; data_addr = 10'd7;
        step();
        check("t6_gnt", 64'(s_gd), 64'(1));
        rst = 1'b1; step(); rst = 1'b0;
        any_dv = 1'b0;
        repeat (4) begin step(); any_dv = any_dv | s_dv; end
        check("t6_no_rvalid", 64'(any_dv), 64'(0));
        do_load(10'd7, rd);
        check("t6_reload", 64'(rd), 64'(ref_mem[7]));
        drain();
        run_random(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
